// File: rtl/mult_div_if.sv
// mult_div_if: request/result bundle between the execute-stage control and
// the iterative multiply/divide unit.
//   start/op/a/b : request, driven by the master (control + register bank)
//   busy/done    : progress handshake, driven by the unit
//   hi/lo/div0   : result registers, driven by the unit
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div0;

  modport master (output start, op, a, b, input busy, done, hi, lo, div0);
  modport slave  (input start, op, a, b, output busy, done, hi, lo, div0);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU, one shift-add or restoring
// divide step per clock, WIDTH steps per operation.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mult_div_if.slave
//             start/op/a/b in; busy, done (1-cycle pulse), hi/lo, div0 out
//   op encoding: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
// Signed ops run on magnitudes; the sign fix-up is applied in FIN.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mult_div_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic               dz_q;     // divide by zero seen at accept
  logic               neg_q;    // operand signs differ
  logic               rneg_q;   // dividend was negative
  logic [WIDTH-1:0]   a_q;      // original A, returned as HI on divide by zero
  logic [WIDTH-1:0]   mb_q;     // |B|: multiplicand or divisor
  logic [2*WIDTH-1:0] acc_q;    // {partial hi / remainder, multiplier / quotient}
  logic               busy_q, done_q, div0_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  // Accept-time operand conditioning
  logic             sgn_op, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign sgn_op = ~bus.op[0];
  assign a_neg  = sgn_op & bus.a[WIDTH-1];
  assign b_neg  = sgn_op & bus.b[WIDTH-1];
  assign a_mag  = a_neg ? -bus.a : bus.a;
  assign b_mag  = b_neg ? -bus.b : bus.b;
  assign b_zero = (bus.b == '0);

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right (carry
  // enters at the top).
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, mb_q} : {(WIDTH+1){1'b0}});
  assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder,
  // trial-subtract. Remainder < divisor always holds, so the shifted value is
  // < 2*divisor and the top bit of the difference is a clean borrow flag.
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_qbit;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_nxt;

  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mb_q};
  assign div_qbit  = ~div_diff[WIDTH];
  assign div_rem   = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_nxt   = {div_rem, acc_q[WIDTH-2:0], div_qbit};

  // Final result with sign fix-up
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;

  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
  assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    fin_hi = prod[2*WIDTH-1:WIDTH];
    fin_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      if (dz_q) begin
        fin_hi = a_q;
        fin_lo = '1;
      end else begin
        fin_hi = rem;
        fin_lo = quo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      a_q      <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            is_div_q <= bus.op[1];
            dz_q     <= bus.op[1] & b_zero;
            neg_q    <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            a_q      <= bus.a;
            mb_q     <= b_mag;
            acc_q    <= {{WIDTH{1'b0}}, a_mag};
            cnt_q    <= '0;
            div0_q   <= 1'b0;
            busy_q   <= 1'b1;
            // Divide by zero has nothing to iterate over
            state_q  <= (bus.op[1] & b_zero) ? S_FIN : S_CALC;
          end
        end
        S_CALC: begin
          acc_q <= is_div_q ? div_nxt : mul_nxt;
          if (cnt_q == CW'(WIDTH-1)) begin
            cnt_q   <= '0;
            state_q <= S_FIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FIN: begin
          hi_q    <= fin_hi;
          lo_q    <= fin_lo;
          div0_q  <= dz_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.div0 = div0_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed + randomized checks of mult_div_unit against a
// plain-arithmetic reference model.
module tb_mult_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   ncmp = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  mult_div_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: results straight from integer arithmetic rules.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] ehi, output logic [31:0] elo,
                       output logic ediv0, output int elat);
    longint p;
    int sx, sy;
    ediv0 = 1'b0;
    elat  = LAT;
    ehi   = '0;
    elo   = '0;
    case (o)
      2'b00: begin
        p = longint'($signed(x)) * longint'($signed(y));
        ehi = p[63:32]; elo = p[31:0];
      end
      2'b01: begin
        p = longint'({32'b0, x}) * longint'({32'b0, y});
        ehi = p[63:32]; elo = p[31:0];
      end
      default: begin
        if (y == 0) begin
          ehi = x; elo = 32'hFFFF_FFFF; ediv0 = 1'b1; elat = 1;
        end else if (o == 2'b11) begin
          elo = x / y; ehi = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          elo = 32'h8000_0000; ehi = 32'h0;
        end else begin
          sx = $signed(x); sy = $signed(y);
          elo = sx / sy; ehi = sx % sy;
        end
      end
    endcase
  endtask

  // Issue one op (accepted at the next rising edge), then follow it to done.
  // pulse_at > 0 drives a second, different start that many cycles after the
  // accept; it must be ignored. Returns in the done cycle, #1 after the edge.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int pulse_at);
    logic [31:0] ehi, elo;
    logic        ediv0;
    int          elat, lat, bcnt;
    bit          seen;
    model(o, x, y, ehi, elo, ediv0, elat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; bcnt = 0; seen = 1'b0;
    while (lat < 200 && !seen) begin
      if (bus.busy) bcnt++;
      if (lat == pulse_at && pulse_at > 0) begin
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd1000; bus.b = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    check({tag, "/latency"}, lat, elat);
    check({tag, "/busy_cycles"}, bcnt, elat);
    check({tag, "/busy_at_done"}, bus.busy, 1'b0);
    check({tag, "/hi"}, bus.hi, ehi);
    check({tag, "/lo"}, bus.lo, elo);
    check({tag, "/div0"}, bus.div0, ediv0);
  endtask

  initial begin
    logic [31:0] hold_hi, hold_lo, ra, rb;
    logic [1:0]  rop;
    bit          done_seen;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/busy", bus.busy, 1'b0);
    check("reset/done", bus.done, 1'b0);
    check("reset/hi",   bus.hi,   32'h0);
    check("reset/lo",   bus.lo,   32'h0);
    check("reset/div0", bus.div0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    do_op("multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("div_b2b",     2'b10, 32'hFFFF_FFF9, 32'd2, 0);   // started in the done cycle
    do_op("divu_zero",   2'b11, 32'd100, 32'd0, 0);
    do_op("divu_100_7",  2'b11, 32'd100, 32'd7, 0);
    do_op("div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("mult_ignore", 2'b00, 32'd5, 32'd6, 10);

    // Results hold while idle
    hold_hi = bus.hi; hold_lo = bus.lo;
    repeat (4) @(posedge clk);
    #1;
    check("hold/done", bus.done, 1'b0);
    check("hold/hi",   bus.hi,   hold_hi);
    check("hold/lo",   bus.lo,   hold_lo);

    // Randomized ops with some forced zero / extreme divisors
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 0);
      if ($urandom_range(0, 3) == 0) repeat (2) @(posedge clk);
    end

    // Reset mid-operation: no done, state and results cleared
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd5; bus.b = 32'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_seen = 1'b0;
    for (int c = 1; c < 20; c++) begin
      if (c == 10) begin
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done) done_seen = 1'b1;
    end
    bus.start = 1'b0;
    check("rst_mid/busy_before", bus.busy, 1'b1);
    check("rst_mid/no_done_before", done_seen, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid/busy", bus.busy, 1'b0);
    check("rst_mid/done", bus.done, 1'b0);
    check("rst_mid/hi",   bus.hi,   32'h0);
    check("rst_mid/lo",   bus.lo,   32'h0);
    check("rst_mid/div0", bus.div0, 1'b0);
    done_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) done_seen = 1'b1;
    end
    check("rst_mid/no_done_in_reset", done_seen, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("mult_after_rst", 2'b00, 32'd5, 32'd6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
